piece_blitter: RTL and testbench

- Draws one 28x28 board cell into the VGA adapter's frame buffer. It walks every pixel of the cell, fetches the pixel from the piece picture ROM, and emits x/y/colour/writeEn.
- Sits directly downstream of view_render. view_render decides which cell to draw and which picture to use, then issues a start request. This block performs the pixel writes and signals done.
- Board origin is (8,8). Cell pitch is 28 px. The frame is 320x240.

---
 rtl/piece_blitter.sv | 149 ++++++++++++++
 tb/tb_piece_blitter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_blitter.sv
// piece_blitter: draws one 28x28 board cell from the piece ROM into the VGA frame buffer.
// Optional SELECT_BOX_EN forces a 2-pixel border to colour 1 when draw_box is latched.
module piece_blitter #(
  parameter int ORIGIN_X = 8,
  parameter int ORIGIN_Y = 8,
  parameter int CELL     = 28
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] cell_x,
  input  logic [2:0] cell_y,
  input  logic [1:0] piece,
  input  logic       draw_box,
  output logic [1:0] rom_sel,
  output logic [9:0] rom_addr,
  input  logic       rom_q,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       colour,
  output logic       writeEn,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  localparam logic [4:0] LAST   = 5'(CELL - 1);
  localparam logic [7:0] CELL_B = 8'(CELL);

  state_t     r_state, w_next;
  logic [4:0] r_px, r_py;
  logic [9:0] r_addr;
  logic [1:0] r_sel;
  logic [8:0] r_bx, r_x1, r_x;
  logic [7:0] r_by, r_y1, r_y;
  logic       r_v1, r_col, r_we;
  logic [8:0] w_bx;
  logic [7:0] w_by;
  logic       w_last, w_go;

`ifdef SELECT_BOX_EN
  logic r_box, r_e1, w_edge;
  assign w_edge = r_box && (r_px < 5'd2 || r_px > LAST - 5'd2 ||
                            r_py < 5'd2 || r_py > LAST - 5'd2);
`else
  logic w_unused_box;
  assign w_unused_box = draw_box;
`endif

  // base = origin + CELL*cell via shift-add over the set bits of CELL
  always_comb begin
    w_bx = 9'(ORIGIN_X);
    w_by = 8'(ORIGIN_Y);
    for (int b = 0; b < 8; b++) begin
      if (CELL_B[b]) begin
        w_bx = w_bx + (9'(cell_x) << b);
        w_by = w_by + (8'(cell_y) << b);
      end
    end
  end

  assign w_last = (r_px == LAST) && (r_py == LAST);
  assign w_go   = (r_state == IDLE) && start;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start)  w_next = SCAN;
      SCAN:  if (w_last) w_next = FLUSH;
      FLUSH: if (!r_v1)  w_next = DONE;
      DONE:              w_next = IDLE;
      default:           w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_px    <= '0;
      r_py    <= '0;
      r_addr  <= '0;
      r_sel   <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_v1    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_col   <= 1'b0;
      r_we    <= 1'b0;
`ifdef SELECT_BOX_EN
      r_box   <= 1'b0;
      r_e1    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_bx   <= w_bx;
        r_by   <= w_by;
        r_sel  <= (piece == 2'd3) ? 2'd0 : piece;
        r_px   <= '0;
        r_py   <= '0;
        r_addr <= '0;
`ifdef SELECT_BOX_EN
        r_box  <= draw_box;
`endif
      end else if (r_state == SCAN && !w_last) begin
        r_addr <= r_addr + 10'd1;
        if (r_px == LAST) begin
          r_px <= '0;
          r_py <= r_py + 5'd1;
        end else begin
          r_px <= r_px + 5'd1;
        end
      end
      // stage 1 lines up the coordinates with the one-cycle ROM read
      r_v1 <= (r_state == SCAN);
      if (r_state == SCAN) begin
        r_x1 <= r_bx + 9'(r_px);
        r_y1 <= r_by + 8'(r_py);
`ifdef SELECT_BOX_EN
        r_e1 <= w_edge;
`endif
      end
      r_we <= r_v1;
      if (r_v1) begin
        r_x   <= r_x1;
        r_y   <= r_y1;
`ifdef SELECT_BOX_EN
        r_col <= rom_q | r_e1;
`else
        r_col <= rom_q;
`endif
      end
    end
  end

  assign rom_sel  = r_sel;
  assign rom_addr = r_addr;
  assign x        = r_x;
  assign y        = r_y;
  assign colour   = r_col;
  assign writeEn  = r_we;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_piece_blitter.sv
// tb_piece_blitter: directed checks of piece_blitter write timing, coordinates and colour.
// Build with +define+SELECT_BOX_EN to exercise the highlight border.
module tb_piece_blitter;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [2:0] cell_x, cell_y;
  logic [1:0] piece;
  logic       draw_box;
  logic [1:0] rom_sel;
  logic [9:0] rom_addr;
  logic       rom_q = 1'b0;
  logic [8:0] x;
  logic [7:0] y;
  logic       colour, writeEn, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_we = 0, n_done = 0, sel_bad = 0;
  int fcyc, lcyc, dcyc;
  int fx, fy, lx, ly, mnx, mxx, mny, mxy;
  logic prev_we = 1'b0;
  logic [1:0] exp_sel = 2'd0;
  logic rom_zero = 1'b0;
  int prx[4];
  int pry[4];
  logic pcol[4];
  int t0, bw, bd, bs;

  always #5 clock = ~clock;

  piece_blitter dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .cell_x   (cell_x),
    .cell_y   (cell_y),
    .piece    (piece),
    .draw_box (draw_box),
    .rom_sel  (rom_sel),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .writeEn  (writeEn),
    .busy     (busy),
    .done     (done)
  );

  // synchronous ROM: one cycle latency, pixel = addr[0] unless forced to 0
  always @(posedge clock) rom_q <= rom_zero ? 1'b0 : rom_addr[0];

  always begin
    @(posedge clock);
    #1;
    cyc = cyc + 1;
    if (writeEn) begin
      if (!prev_we) begin
        fcyc = cyc;
        fx = int'(x); fy = int'(y);
        mnx = int'(x); mxx = int'(x);
        mny = int'(y); mxy = int'(y);
        for (int k = 0; k < 4; k++) pcol[k] = 1'bx;
      end
      lcyc = cyc;
      lx = int'(x); ly = int'(y);
      if (int'(x) < mnx) mnx = int'(x);
      if (int'(x) > mxx) mxx = int'(x);
      if (int'(y) < mny) mny = int'(y);
      if (int'(y) > mxy) mxy = int'(y);
      for (int k = 0; k < 4; k++)
        if (int'(x) == prx[k] && int'(y) == pry[k]) pcol[k] = colour;
      n_we = n_we + 1;
    end
    prev_we = writeEn;
    if (done) begin
      n_done = n_done + 1;
      dcyc = cyc;
    end
    if (busy && rom_sel !== exp_sel) sel_bad = sel_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total = total + 1;
    assert (o === e) else begin
      bad = bad + 1;
      $error("FAIL %s: got %0d want %0d", tag, o, e);
    end
  endtask

  // call at a negedge; returns at the negedge where done is seen
  task automatic draw(input logic [2:0] cx, input logic [2:0] cy,
                      input logic [1:0] pc, input logic bx,
                      input int rep);
    exp_sel = (pc == 2'd3) ? 2'd0 : pc;
    bw = n_we; bd = n_done; bs = sel_bad;
    cell_x = cx; cell_y = cy; piece = pc; draw_box = bx;
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clock);
    start = 1'b0;
    while (!done && cyc < t0 + 1000) begin
      start = (rep > 0 && cyc == t0 + rep - 1);
      @(negedge clock);
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    cell_x = '0; cell_y = '0; piece = '0; draw_box = 1'b0;
    prx = '{0, 0, 0, 0};
    pry = '{0, 0, 0, 0};
    repeat (3) @(negedge clock);
    chk("rst_we",   32'(writeEn), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_x",    32'(x), 0);
    chk("rst_y",    32'(y), 0);
    chk("rst_col",  32'(colour), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_sel",  32'(rom_sel), 0);
    reset = 1'b0;
    @(negedge clock);

    // cell (0,0), black
    prx = '{8, 9, 35, 20};
    pry = '{8, 8, 35, 8};
    draw(3'd0, 3'd0, 2'd1, 1'b0, 0);
    chk("t1_first_cyc", fcyc - t0, 2);
    chk("t1_fx", fx, 8);
    chk("t1_fy", fy, 8);
    chk("t1_lx", lx, 35);
    chk("t1_ly", ly, 35);
    chk("t1_nwe", n_we - bw, 784);
    chk("t1_contig", lcyc - fcyc, 783);
    chk("t1_done_cyc", dcyc - t0, 786);
    chk("t1_ndone", n_done - bd, 1);
    chk("t1_sel", sel_bad - bs, 0);
    chk("t1_busy_at_done", 32'(busy), 1);
    chk("t1_c0", 32'(pcol[0]), 0);
    chk("t1_c1", 32'(pcol[1]), 1);
    chk("t1_c2", 32'(pcol[2]), 1);
    chk("t1_c3", 32'(pcol[3]), 0);
    @(negedge clock);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_done", 32'(done), 0);
    chk("t1_idle_we", 32'(writeEn), 0);
    chk("t1_hold_x", 32'(x), 35);
    chk("t1_hold_y", 32'(y), 35);

    // cell (7,7), white
    prx = '{204, 205, 231, 206};
    pry = '{204, 204, 231, 210};
    draw(3'd7, 3'd7, 2'd2, 1'b0, 0);
    chk("t2_minx", mnx, 204);
    chk("t2_maxx", mxx, 231);
    chk("t2_miny", mny, 204);
    chk("t2_maxy", mxy, 231);
    chk("t2_nwe", n_we - bw, 784);
    chk("t2_sel", sel_bad - bs, 0);
    chk("t2_c0", 32'(pcol[0]), 0);
    chk("t2_c1", 32'(pcol[1]), 1);
    chk("t2_c2", 32'(pcol[2]), 1);
    chk("t2_c3", 32'(pcol[3]), 0);
    @(negedge clock);

    // reserved picture draws as empty
    draw(3'd2, 3'd5, 2'd3, 1'b0, 0);
    chk("t3_sel", sel_bad - bs, 0);
    chk("t3_fx", fx, 64);
    chk("t3_fy", fy, 148);
    chk("t3_lx", lx, 91);
    chk("t3_ly", ly, 175);
    chk("t3_nwe", n_we - bw, 784);
    @(negedge clock);

    // start pulse mid-draw is ignored
    draw(3'd4, 3'd1, 2'd1, 1'b0, 100);
    chk("t4_nwe", n_we - bw, 784);
    chk("t4_ndone", n_done - bd, 1);
    chk("t4_done_cyc", dcyc - t0, 786);
    chk("t4_fx", fx, 120);
    chk("t4_fy", fy, 36);
    @(negedge clock);
    chk("t4_no_restart", 32'(busy), 0);

    // reset at cycle 300 of a draw
    exp_sel = 2'd1;
    bw = n_we; bd = n_done;
    cell_x = 3'd1; cell_y = 3'd1; piece = 2'd1; draw_box = 1'b0;
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clock);
    start = 1'b0;
    while (cyc < t0 + 299) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_rst_we", 32'(writeEn), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_addr", 32'(rom_addr), 0);
    chk("t5_partial_nwe", n_we - bw, 298);
    reset = 1'b0;
    repeat (800) @(negedge clock);
    chk("t5_no_done", n_done - bd, 0);
    draw(3'd1, 3'd1, 2'd1, 1'b0, 0);
    chk("t5_nwe", n_we - bw, 784);
    chk("t5_fx", fx, 36);
    chk("t5_fy", fy, 36);
    chk("t5_lx", lx, 63);
    chk("t5_ly", ly, 63);
    chk("t5_ndone", n_done - bd, 1);
    @(negedge clock);

    // select box over a blank ROM
    rom_zero = 1'b1;
    prx = '{92, 93, 119, 94};
    pry = '{64, 65, 91, 66};
    draw(3'd3, 3'd2, 2'd1, 1'b1, 0);
    chk("t6_nwe", n_we - bw, 784);
    chk("t6_done_cyc", dcyc - t0, 786);
`ifdef SELECT_BOX_EN
    chk("t6_c0", 32'(pcol[0]), 1);
    chk("t6_c1", 32'(pcol[1]), 1);
    chk("t6_c2", 32'(pcol[2]), 1);
`else
    chk("t6_c0", 32'(pcol[0]), 0);
    chk("t6_c1", 32'(pcol[1]), 0);
    chk("t6_c2", 32'(pcol[2]), 0);
`endif
    chk("t6_c3", 32'(pcol[3]), 0);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
